// File: rtl/gba_irq_pkg.sv
// Shared definitions for the GBA interrupt controller: CPSR IRQ mode code,
// default source count and level mask, and the source index map.
package gba_irq_pkg;

  localparam logic [4:0]  CPSR_IRQ           = 5'b10010;
  localparam int unsigned N_SRC_DEFAULT      = 14;
  localparam logic [31:0] LEVEL_MASK_DEFAULT = '0;

  typedef enum int unsigned {
    IRQ_VBLANK  = 0,
    IRQ_HBLANK  = 1,
    IRQ_VCOUNT  = 2,
    IRQ_TIMER0  = 3,
    IRQ_TIMER1  = 4,
    IRQ_TIMER2  = 5,
    IRQ_TIMER3  = 6,
    IRQ_SERIAL  = 7,
    IRQ_DMA0    = 8,
    IRQ_DMA1    = 9,
    IRQ_DMA2    = 10,
    IRQ_DMA3    = 11,
    IRQ_KEYPAD  = 12,
    IRQ_GAMEPAK = 13
  } irq_src_e;

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: optional 2-flop synchronizer (IRQ_SYNC_EN),
// edge/level hit detection and the sticky request flag (set wins over clear).
module irq_src_cell #(
  parameter bit LEVEL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic src,
  input  logic clr,
  output logic flag
);

  logic s;
  logic samp_q, samp_d;
  logic flag_q, flag_d;
  logic hit;

`ifdef IRQ_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Synchronizer next-state.
  always_comb begin
    sync1_d = src;
    sync2_d = sync1_q;
  end

  // Synchronizer flops, cleared on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s = sync2_q;
`else
  assign s = src;
`endif

  // Hit detection and flag next-state.
  always_comb begin
    samp_d = s;
    hit    = LEVEL ? s : (s & ~samp_q);
    flag_d = (flag_q & ~clr) | hit;
  end

  // Previous-sample and flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      samp_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      samp_q <= samp_d;
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/irq_ctrl_n.sv
// Interrupt controller top: per-source flag cells, enable masking, lowest-index
// priority encoder and the registered active-low nIRQ line.
// Build option: define IRQ_SYNC_EN to synchronize every source with 2 flops.
module irq_ctrl_n
  import gba_irq_pkg::*;
#(
  parameter int unsigned N_SRC      = N_SRC_DEFAULT,
  parameter logic [31:0] LEVEL_MASK = LEVEL_MASK_DEFAULT,
  parameter int unsigned ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             ime,
  input  logic [N_SRC-1:0] reg_ie,
  input  logic             ack_we,
  input  logic [N_SRC-1:0] ack_data,
  input  logic [4:0]       cpu_mode,
  output logic [N_SRC-1:0] reg_if,
  output logic             irq_pending,
  output logic [ID_W-1:0]  irq_id,
  output logic             nIRQ
);

  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] masked;
  logic             nirq_q, nirq_d;
  logic             found;

  assign clr = ack_we ? ack_data : '0;

  for (genvar i = 0; i < N_SRC; i++) begin : g_cell
    irq_src_cell #(
      .LEVEL(LEVEL_MASK[i])
    ) u_cell (
      .clock(clock),
      .reset(reset),
      .src  (src[i]),
      .clr  (clr[i]),
      .flag (reg_if[i])
    );
  end

  // Masking and lowest-index-first priority encode.
  always_comb begin
    masked      = reg_if & reg_ie;
    irq_pending = |masked;
    irq_id      = '0;
    found       = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (masked[i] && !found) begin
        irq_id = ID_W'(i);
        found  = 1'b1;
      end
    end
    nirq_d = ~(ime & irq_pending & (cpu_mode != CPSR_IRQ));
  end

  // Registered nIRQ, deasserted (high) on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) nirq_q <= 1'b1;
    else       nirq_q <= nirq_d;
  end

  assign nIRQ = nirq_q;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Self-checking bench for irq_ctrl_n: a cycle-level behavioural model compared
// on every falling edge, plus directed literal checks from the test plan.
module tb_irq_ctrl_n;
  import gba_irq_pkg::*;

  localparam int unsigned N    = 14;
  localparam logic [31:0] LMSK = 32'h0000_0020;
`ifdef IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   src, reg_ie, ack_data, reg_if;
  logic           ime, ack_we, irq_pending, nIRQ;
  logic [4:0]     cpu_mode;
  logic [3:0]     irq_id;

  int passed = 0;
  int total  = 0;

  irq_ctrl_n #(.N_SRC(N), .LEVEL_MASK(LMSK)) dut (
    .clock(clock), .reset(reset), .src(src), .ime(ime), .reg_ie(reg_ie),
    .ack_we(ack_we), .ack_data(ack_data), .cpu_mode(cpu_mode),
    .reg_if(reg_if), .irq_pending(irq_pending), .irq_id(irq_id), .nIRQ(nIRQ)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // ---------------- behavioural model ----------------
  bit [N-1:0] m_if, m_prev, m_h0, m_h1;
  bit         m_nirq;

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clock or posedge reset) begin
    bit [N-1:0] eff, hit;
    if (reset) begin
      m_if = '0; m_prev = '0; m_h0 = '0; m_h1 = '0; m_nirq = 1'b1;
    end else begin
      eff = (SYNC_LAT != 0) ? m_h1 : src;
      m_h1 = m_h0;
      m_h0 = src;
      m_nirq = !(ime && ((m_if & reg_ie) != 0) && (cpu_mode != CPSR_IRQ));
      for (int i = 0; i < N; i++)
        hit[i] = LMSK[i] ? eff[i] : (eff[i] && !m_prev[i]);
      m_prev = eff;
      m_if = (m_if & ~(ack_we ? ack_data : '0)) | hit;
    end
  end

  // Compare process: every falling edge.
  always @(negedge clock) begin
    chk("model reg_if", 32'(reg_if), 32'(m_if));
    chk("model irq_pending", 32'(irq_pending), 32'((m_if & reg_ie) != 0));
    chk("model irq_id", 32'(irq_id), 32'(lowest(m_if & reg_ie)));
    chk("model nIRQ", 32'(nIRQ), 32'(m_nirq));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic ack(input logic [N-1:0] m);
    ack_we = 1'b1; ack_data = m;
    step(1);
    ack_we = 1'b0; ack_data = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " reg_if"}, 32'(reg_if), 32'h0);
    chk({tag, " nIRQ"}, 32'(nIRQ), 32'h1);
    chk({tag, " irq_pending"}, 32'(irq_pending), 32'h0);
    chk({tag, " irq_id"}, 32'(irq_id), 32'h0);
  endtask

  initial begin
    reset = 1'b1; src = '0; ime = 1'b1; reg_ie = 14'h3FFF;
    ack_we = 1'b0; ack_data = '0; cpu_mode = 5'h1F;
    #1 chk_reset("reset");
    step(2);
    reset = 1'b0;
    step(2);

    // Edge source 0: 1-cycle pulse, flag then nIRQ one cycle later.
    src = 14'h0001; step(1); src = '0;
    step(SYNC_LAT);
    chk("pulse0 flag", 32'(reg_if[0]), 32'h1);
    chk("pulse0 nIRQ early", 32'(nIRQ), 32'h1);
    step(1);
    chk("pulse0 nIRQ", 32'(nIRQ), 32'h0);
    ack(14'h0001);
    chk("ack0 flag", 32'(reg_if[0]), 32'h0);
    chk("ack0 nIRQ still low", 32'(nIRQ), 32'h0);
    step(1);
    chk("ack0 nIRQ", 32'(nIRQ), 32'h1);

    // Source 0 held high for 10 cycles sets once only.
    src = 14'h0001; step(SYNC_LAT + 2);
    ack(14'h0001);
    step(8);
    chk("held0 no reflag", 32'(reg_if[0]), 32'h0);
    src = '0; step(SYNC_LAT + 2);

    // Ack race on source 3: set wins.
    src = 14'h0008; step(SYNC_LAT);
    ack(14'h0008);
    src = '0;
    chk("race3 set wins", 32'(reg_if[3]), 32'h1);
    step(3);
    ack(14'h0008);
    chk("ack3 flag", 32'(reg_if[3]), 32'h0);
    step(1);
    chk("ack3 nIRQ", 32'(nIRQ), 32'h1);

    // Level source 5.
    src = 14'h0020; step(SYNC_LAT + 1);
    chk("lvl5 flag", 32'(reg_if[5]), 32'h1);
    ack(14'h0020);
    chk("lvl5 held after ack", 32'(reg_if[5]), 32'h1);
    src = '0; step(SYNC_LAT + 1);
    chk("lvl5 dropped still set", 32'(reg_if[5]), 32'h1);
    ack(14'h0020);
    chk("lvl5 cleared", 32'(reg_if[5]), 32'h0);
    step(2);

    // Priority: flags 13, 4, 2.
    src = 14'h2014; step(1); src = '0; step(SYNC_LAT);
    chk("prio flags", 32'(reg_if), 32'h2014);
    chk("prio id 2", 32'(irq_id), 32'h2);
    reg_ie = 14'h3FFB; #1;
    chk("prio id 4", 32'(irq_id), 32'h4);
    chk("prio pending", 32'(irq_pending), 32'h1);

    // ack_data ignored without ack_we.
    ack_data = 14'h3FFF; step(1); ack_data = '0;
    chk("ack_data ignored", 32'(reg_if), 32'h2014);

    // Gating by ime and cpu_mode.
    reg_ie = 14'h3FFF; step(1);
    chk("gate nIRQ low", 32'(nIRQ), 32'h0);
    ime = 1'b0; step(1);
    chk("ime0 nIRQ", 32'(nIRQ), 32'h1);
    chk("ime0 pending", 32'(irq_pending), 32'h1);
    ime = 1'b1; cpu_mode = CPSR_IRQ; step(1);
    chk("irq mode nIRQ", 32'(nIRQ), 32'h1);
    cpu_mode = 5'h1F; step(1);
    chk("return nIRQ", 32'(nIRQ), 32'h0);

    // Reset mid-run with 5 flags set.
    ack(14'h3FFF);
    src = 14'h1243; step(1); src = '0; step(SYNC_LAT + 1);
    chk("pre-reset flags", 32'(reg_if), 32'h1243);
    chk("pre-reset nIRQ", 32'(nIRQ), 32'h0);
    reset = 1'b1; #1;
    chk_reset("async reset");
    step(2);
    reset = 1'b0;
    step(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
